vproc_vreg_fetch_seq: RTL and testbench

- Operand-fetch sequencer between the decode/dispatch queue and the execution units (ALU, MUL, SLD, ELEM).
- Accepts one decoded vector instruction per handshake and expands it into per-cycle fetch beats, one beat per vector register of the destination group.
- Each beat carries vs1/vs2 register-file read addresses, read enables, narrow-half selects, the vd address and hazard-clear masks.
- Implements the per-beat fetch_info addressing and fetch/shift/clear_hazard rules in hardware.

---
 rtl/vproc_vreg_fetch_seq_pkg.sv | 43 ++++
 rtl/vproc_vreg_fetch_seq.sv | 193 +++++++++++++++++++
 tb/tb_vproc_vreg_fetch_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_vreg_fetch_seq_pkg.sv
// Shared types and helpers for the vector register operand-fetch sequencer.
package vproc_vreg_fetch_seq_pkg;

    typedef enum logic [1:0] {
        EMUL_1,
        EMUL_2,
        EMUL_4,
        EMUL_8
    } cfg_emul_e;

    typedef enum logic [1:0] {
        OP_SINGLEWIDTH,
        OP_WIDENING,
        OP_WIDENING_VS2,
        OP_NARROWING
    } op_widenarrow_e;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] vd_addr;
        logic       rs1_rd;
        logic       rs2_rd;
        logic       rs1_shift;
        logic       rs2_shift;
        logic       first;
        logic       last;
    } fetch_beat_t;

    // {n1, n2, nd}: vs1 narrow, vs2 narrow, vd narrow
    function automatic logic [2:0] narrow_flags(input logic [1:0] widenarrow);
        logic n1, n2, nd;
        n1 = (widenarrow != OP_SINGLEWIDTH);
        n2 = (widenarrow == OP_WIDENING);
        nd = (widenarrow == OP_NARROWING);
        return {n1, n2, nd};
    endfunction

    function automatic logic [3:0] emul_beats(input logic [1:0] cfg_emul);
        return 4'd1 << cfg_emul;
    endfunction

endpackage

// File: rtl/vproc_vreg_fetch_seq.sv
// Expands one decoded vector instruction into per-register fetch beats with
// read addresses, narrow-half selects and hazard-clear masks.
module vproc_vreg_fetch_seq
    import vproc_vreg_fetch_seq_pkg::*;
#(
    parameter int unsigned OP_W         = 12,
    parameter bit          CLR_ON_FETCH = 1'b1
) (
    input  logic            clk_i,
    input  logic            async_rst_ni,

    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [1:0]      op_emul_i,
    input  logic [1:0]      op_widenarrow_i,
    input  logic            op_rs1_vreg_i,
    input  logic            op_rs2_vreg_i,
    input  logic [4:0]      op_rs1_addr_i,
    input  logic [4:0]      op_rs2_addr_i,
    input  logic [4:0]      op_vd_addr_i,
    input  logic [OP_W-1:0] op_mode_i,

    output logic            beat_valid_o,
    input  logic            beat_ready_i,
    output logic [4:0]      beat_rs1_addr_o,
    output logic [4:0]      beat_rs2_addr_o,
    output logic [4:0]      beat_vd_addr_o,
    output logic            beat_rs1_rd_o,
    output logic            beat_rs2_rd_o,
    output logic            beat_rs1_shift_o,
    output logic            beat_rs2_shift_o,
    output logic            beat_first_o,
    output logic            beat_last_o,
    output logic [OP_W-1:0] beat_mode_o,
    output logic [31:0]     hz_clr_o
);

    logic            busy_q, busy_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      emul_q, emul_d;
    logic [2:0]      nflags_q, nflags_d;
    logic            rs1_vreg_q, rs1_vreg_d;
    logic            rs2_vreg_q, rs2_vreg_d;
    logic [4:0]      rs1_base_q, rs1_base_d;
    logic [4:0]      rs2_base_q, rs2_base_d;
    logic [4:0]      vd_base_q, vd_base_d;
    logic [OP_W-1:0] mode_q, mode_d;

    logic            n1, n2, nd;
    logic [3:0]      beats;
    logic            last;
    logic            accept;
    logic [2:0]      off1, off2, offd;
    logic            clr1, clr2;
    fetch_beat_t     beat;
    logic [31:0]     hz_fetch, hz_final;

    // Every register a vector operand touches across the whole instruction.
    function automatic logic [31:0] group_mask(input logic [4:0] base, input logic narrow,
                                               input logic [3:0] nbeats);
        logic [31:0] m;
        logic [2:0]  off;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            off = narrow ? 3'(i >> 1) : 3'(i);
            if (4'(i) < nbeats) begin
                m[base | {2'b00, off}] = 1'b1;
            end
        end
        return m;
    endfunction

    assign {n1, n2, nd} = nflags_q;
    assign beats        = emul_beats(emul_q);
    assign last         = ({1'b0, cnt_q} == beats - 4'd1);
    assign op_ready_o   = ~busy_q | (beat_ready_i & last);
    assign accept       = op_valid_i & op_ready_o;

    always_comb begin
        off1 = n1 ? (cnt_q >> 1) : cnt_q;
        off2 = n2 ? (cnt_q >> 1) : cnt_q;
        offd = nd ? (cnt_q >> 1) : cnt_q;

        beat           = '0;
        beat.rs1_addr  = rs1_base_q | {2'b00, off1};
        beat.rs2_addr  = rs2_base_q | {2'b00, off2};
        beat.vd_addr   = vd_base_q  | {2'b00, offd};
        beat.rs1_rd    = rs1_vreg_q & (~n1 | ~cnt_q[0]);
        beat.rs2_rd    = rs2_vreg_q & (~n2 | ~cnt_q[0]);
        beat.rs1_shift = n1 & cnt_q[0];
        beat.rs2_shift = n2 & cnt_q[0];
        beat.first     = (cnt_q == 3'd0);
        beat.last      = last;

        // A narrow register is read twice (both halves); clear after the upper half.
        clr1 = rs1_vreg_q & (~n1 | cnt_q[0] | last);
        clr2 = rs2_vreg_q & (~n2 | cnt_q[0] | last);

        hz_fetch = '0;
        if (clr1) hz_fetch = hz_fetch | (32'd1 << beat.rs1_addr);
        if (clr2) hz_fetch = hz_fetch | (32'd1 << beat.rs2_addr);

        hz_final = '0;
        if (last) begin
            if (rs1_vreg_q) hz_final = hz_final | group_mask(rs1_base_q, n1, beats);
            if (rs2_vreg_q) hz_final = hz_final | group_mask(rs2_base_q, n2, beats);
        end
    end

    always_comb begin
        beat_valid_o     = busy_q;
        beat_rs1_addr_o  = busy_q ? beat.rs1_addr  : 5'd0;
        beat_rs2_addr_o  = busy_q ? beat.rs2_addr  : 5'd0;
        beat_vd_addr_o   = busy_q ? beat.vd_addr   : 5'd0;
        beat_rs1_rd_o    = busy_q & beat.rs1_rd;
        beat_rs2_rd_o    = busy_q & beat.rs2_rd;
        beat_rs1_shift_o = busy_q & beat.rs1_shift;
        beat_rs2_shift_o = busy_q & beat.rs2_shift;
        beat_first_o     = busy_q & beat.first;
        beat_last_o      = busy_q & beat.last;
        beat_mode_o      = busy_q ? mode_q : '0;
        hz_clr_o         = '0;
        if (busy_q) begin
            hz_clr_o = CLR_ON_FETCH ? hz_fetch : hz_final;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        emul_d     = emul_q;
        nflags_d   = nflags_q;
        rs1_vreg_d = rs1_vreg_q;
        rs2_vreg_d = rs2_vreg_q;
        rs1_base_d = rs1_base_q;
        rs2_base_d = rs2_base_q;
        vd_base_d  = vd_base_q;
        mode_d     = mode_q;
        if (accept) begin
            busy_d     = 1'b1;
            cnt_d      = 3'd0;
            emul_d     = op_emul_i;
            nflags_d   = narrow_flags(op_widenarrow_i);
            rs1_vreg_d = op_rs1_vreg_i;
            rs2_vreg_d = op_rs2_vreg_i;
            rs1_base_d = op_rs1_addr_i;
            rs2_base_d = op_rs2_addr_i;
            vd_base_d  = op_vd_addr_i;
            mode_d     = op_mode_i;
        end else if (busy_q & beat_ready_i) begin
            if (last) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            busy_q     <= 1'b0;
            cnt_q      <= 3'd0;
            emul_q     <= 2'd0;
            nflags_q   <= 3'd0;
            rs1_vreg_q <= 1'b0;
            rs2_vreg_q <= 1'b0;
            rs1_base_q <= 5'd0;
            rs2_base_q <= 5'd0;
            vd_base_q  <= 5'd0;
            mode_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            emul_q     <= emul_d;
            nflags_q   <= nflags_d;
            rs1_vreg_q <= rs1_vreg_d;
            rs2_vreg_q <= rs2_vreg_d;
            rs1_base_q <= rs1_base_d;
            rs2_base_q <= rs2_base_d;
            vd_base_q  <= vd_base_d;
            mode_q     <= mode_d;
        end
    end

    // Wide operand groups must start on a group boundary; OR addressing does not fix them up.
    a_rs1_aligned: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        (busy_q && rs1_vreg_q && !n1) |-> ((rs1_base_q & {1'b0, beats - 4'd1}) == 5'd0))
        else $error("vs1 group base misaligned");
    a_rs2_aligned: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        (busy_q && rs2_vreg_q && !n2) |-> ((rs2_base_q & {1'b0, beats - 4'd1}) == 5'd0))
        else $error("vs2 group base misaligned");

endmodule

// File: tb/tb_vproc_vreg_fetch_seq.sv
// Directed-vector bench for the operand-fetch sequencer (default CLR_ON_FETCH=1).
module tb_vproc_vreg_fetch_seq;
    import vproc_vreg_fetch_seq_pkg::*;

    localparam int unsigned OP_W = 12;

    logic            clk_i = 1'b0;
    logic            async_rst_ni;
    logic            op_valid_i;
    logic            op_ready_o;
    logic [1:0]      op_emul_i;
    logic [1:0]      op_widenarrow_i;
    logic            op_rs1_vreg_i, op_rs2_vreg_i;
    logic [4:0]      op_rs1_addr_i, op_rs2_addr_i, op_vd_addr_i;
    logic [OP_W-1:0] op_mode_i;
    logic            beat_valid_o;
    logic            beat_ready_i;
    logic [4:0]      beat_rs1_addr_o, beat_rs2_addr_o, beat_vd_addr_o;
    logic            beat_rs1_rd_o, beat_rs2_rd_o;
    logic            beat_rs1_shift_o, beat_rs2_shift_o;
    logic            beat_first_o, beat_last_o;
    logic [OP_W-1:0] beat_mode_o;
    logic [31:0]     hz_clr_o;

    int n_vec = 0;
    int n_err = 0;

    vproc_vreg_fetch_seq #(
        .OP_W        (OP_W),
        .CLR_ON_FETCH(1'b1)
    ) dut (
        .clk_i           (clk_i),
        .async_rst_ni    (async_rst_ni),
        .op_valid_i      (op_valid_i),
        .op_ready_o      (op_ready_o),
        .op_emul_i       (op_emul_i),
        .op_widenarrow_i (op_widenarrow_i),
        .op_rs1_vreg_i   (op_rs1_vreg_i),
        .op_rs2_vreg_i   (op_rs2_vreg_i),
        .op_rs1_addr_i   (op_rs1_addr_i),
        .op_rs2_addr_i   (op_rs2_addr_i),
        .op_vd_addr_i    (op_vd_addr_i),
        .op_mode_i       (op_mode_i),
        .beat_valid_o    (beat_valid_o),
        .beat_ready_i    (beat_ready_i),
        .beat_rs1_addr_o (beat_rs1_addr_o),
        .beat_rs2_addr_o (beat_rs2_addr_o),
        .beat_vd_addr_o  (beat_vd_addr_o),
        .beat_rs1_rd_o   (beat_rs1_rd_o),
        .beat_rs2_rd_o   (beat_rs2_rd_o),
        .beat_rs1_shift_o(beat_rs1_shift_o),
        .beat_rs2_shift_o(beat_rs2_shift_o),
        .beat_first_o    (beat_first_o),
        .beat_last_o     (beat_last_o),
        .beat_mode_o     (beat_mode_o),
        .hz_clr_o        (hz_clr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int rs1, input int rs2, input int vd,
                              input bit rd1, input bit rd2, input bit sh1, input bit sh2,
                              input bit first, input bit last, input logic [31:0] hz);
        check({tag, ".valid"}, 32'(beat_valid_o), 32'd1);
        check({tag, ".rs1"},   32'(beat_rs1_addr_o), 32'(rs1));
        check({tag, ".rs2"},   32'(beat_rs2_addr_o), 32'(rs2));
        check({tag, ".vd"},    32'(beat_vd_addr_o), 32'(vd));
        check({tag, ".rd1"},   32'(beat_rs1_rd_o), 32'(rd1));
        check({tag, ".rd2"},   32'(beat_rs2_rd_o), 32'(rd2));
        check({tag, ".sh1"},   32'(beat_rs1_shift_o), 32'(sh1));
        check({tag, ".sh2"},   32'(beat_rs2_shift_o), 32'(sh2));
        check({tag, ".first"}, 32'(beat_first_o), 32'(first));
        check({tag, ".last"},  32'(beat_last_o), 32'(last));
        check({tag, ".hz"},    hz_clr_o, hz);
    endtask

    task automatic set_op(input logic [1:0] emul, input logic [1:0] wn, input logic v1,
                          input logic v2, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] vd, input logic [OP_W-1:0] mode);
        op_emul_i       = emul;
        op_widenarrow_i = wn;
        op_rs1_vreg_i   = v1;
        op_rs2_vreg_i   = v2;
        op_rs1_addr_i   = a1;
        op_rs2_addr_i   = a2;
        op_vd_addr_i    = vd;
        op_mode_i       = mode;
        op_valid_i      = 1'b1;
    endtask

    // Issue into an idle sequencer; returns #1 after the accepting edge.
    task automatic send_op(input logic [1:0] emul, input logic [1:0] wn, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] vd,
                           input logic [OP_W-1:0] mode);
        set_op(emul, wn, 1'b1, 1'b1, a1, a2, vd, mode);
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
    endtask

    task automatic next_beat();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        async_rst_ni = 1'b0;
        op_valid_i   = 1'b0;
        beat_ready_i = 1'b0;
        set_op(2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
        op_valid_i   = 1'b0;
        #12;
        async_rst_ni = 1'b1;

        @(negedge clk_i);
        check("rst.valid", 32'(beat_valid_o), 32'd0);
        check("rst.ready", 32'(op_ready_o), 32'd1);
        check("rst.hz",    hz_clr_o, 32'd0);
        check("rst.rs1",   32'(beat_rs1_addr_o), 32'd0);
        check("rst.first", 32'(beat_first_o), 32'd0);

        // EMUL_4 single-width
        beat_ready_i = 1'b1;
        send_op(EMUL_4, OP_SINGLEWIDTH, 5'd8, 5'd16, 5'd4, 12'hA5C);
        @(negedge clk_i);
        check("sw.mode", 32'(beat_mode_o), 32'hA5C);
        check_beat("sw0", 8, 16, 4, 1, 1, 0, 0, 1, 0, 32'h0001_0100);
        next_beat(); @(negedge clk_i);
        check_beat("sw1", 9, 17, 5, 1, 1, 0, 0, 0, 0, 32'h0002_0200);
        next_beat(); @(negedge clk_i);
        check_beat("sw2", 10, 18, 6, 1, 1, 0, 0, 0, 0, 32'h0004_0400);
        check("sw2.ready", 32'(op_ready_o), 32'd0);
        next_beat(); @(negedge clk_i);
        check_beat("sw3", 11, 19, 7, 1, 1, 0, 0, 0, 1, 32'h0008_0800);
        check("sw3.ready", 32'(op_ready_o), 32'd1);
        next_beat(); @(negedge clk_i);
        check("sw.idle", 32'(beat_valid_o), 32'd0);
        check("sw.idle_hz", hz_clr_o, 32'd0);

        // EMUL_2 widening: both sources narrow
        send_op(EMUL_2, OP_WIDENING, 5'd3, 5'd5, 5'd6, 12'h001);
        @(negedge clk_i);
        check_beat("wd0", 3, 5, 6, 1, 1, 0, 0, 1, 0, 32'h0000_0000);
        next_beat(); @(negedge clk_i);
        check_beat("wd1", 3, 5, 7, 0, 0, 1, 1, 0, 1, 32'h0000_0028);
        next_beat();

        // EMUL_4 narrowing: vs2 wide, vs1 and vd narrow
        send_op(EMUL_4, OP_NARROWING, 5'd2, 5'd8, 5'd2, 12'h002);
        @(negedge clk_i);
        check_beat("nr0", 2, 8, 2, 1, 1, 0, 0, 1, 0, 32'h0000_0100);
        next_beat(); @(negedge clk_i);
        check_beat("nr1", 2, 9, 2, 0, 1, 1, 0, 0, 0, 32'h0000_0204);
        next_beat(); @(negedge clk_i);
        check_beat("nr2", 3, 10, 3, 1, 1, 0, 0, 0, 0, 32'h0000_0400);
        next_beat(); @(negedge clk_i);
        check_beat("nr3", 3, 11, 3, 0, 1, 1, 0, 0, 1, 32'h0000_0808);
        next_beat();

        // Back-to-back EMUL_1; second op has a scalar vs2
        set_op(EMUL_1, OP_SINGLEWIDTH, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 12'h111);
        @(posedge clk_i);
        #1;
        set_op(EMUL_1, OP_WIDENING, 1'b1, 1'b0, 5'd4, 5'd21, 5'd6, 12'h222);
        @(negedge clk_i);
        check_beat("bb0", 1, 2, 3, 1, 1, 0, 0, 1, 1, 32'h0000_0006);
        check("bb0.ready", 32'(op_ready_o), 32'd1);
        check("bb0.mode", 32'(beat_mode_o), 32'h111);
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        @(negedge clk_i);
        check_beat("bb1", 4, 21, 6, 1, 0, 0, 0, 1, 1, 32'h0000_0010);
        check("bb1.ready", 32'(op_ready_o), 32'd1);
        check("bb1.mode", 32'(beat_mode_o), 32'h222);
        next_beat(); @(negedge clk_i);
        check("bb.idle", 32'(beat_valid_o), 32'd0);

        // Backpressure on beat 0 of an EMUL_2 op
        beat_ready_i = 1'b0;
        send_op(EMUL_2, OP_SINGLEWIDTH, 5'd12, 5'd14, 5'd24, 12'h333);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_beat($sformatf("bp_hold%0d", i), 12, 14, 24, 1, 1, 0, 0, 1, 0,
                       32'h0000_5000);
            check($sformatf("bp_hold%0d.ready", i), 32'(op_ready_o), 32'd0);
        end
        #1;
        beat_ready_i = 1'b1;
        #1;
        check("bp_rel.ready", 32'(op_ready_o), 32'd0);
        check("bp_rel.rs1", 32'(beat_rs1_addr_o), 32'd12);
        next_beat(); @(negedge clk_i);
        check_beat("bp1", 13, 15, 25, 1, 1, 0, 0, 0, 1, 32'h0000_a000);
        check("bp1.ready", 32'(op_ready_o), 32'd1);
        next_beat();

        // Asynchronous reset during beat 2 of an EMUL_8 op
        send_op(EMUL_8, OP_SINGLEWIDTH, 5'd0, 5'd8, 5'd16, 12'h444);
        next_beat();
        next_beat();
        @(negedge clk_i);
        check_beat("rs2b", 2, 10, 18, 1, 1, 0, 0, 0, 0, 32'h0000_0404);
        #2;
        async_rst_ni = 1'b0;
        #1;
        check("rs.valid_async", 32'(beat_valid_o), 32'd0);
        check("rs.hz_async", hz_clr_o, 32'd0);
        @(posedge clk_i);
        #3;
        async_rst_ni = 1'b1;
        @(negedge clk_i);
        check("rs.ready_after", 32'(op_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rs.no_stale%0d", i), 32'(beat_valid_o), 32'd0);
            @(negedge clk_i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
